int_to_double: RTL and testbench

Pipelined converter from a 64-bit two's-complement signed integer to an IEEE 754 binary64 (double-precision) value. It accepts one operand per clock with no handshake and delivers the result a fixed number of cycles later. It serves as the integer-to-floating-point conversion unit of the math component library. It sits in front of double-precision arithmetic blocks or feeds results to file/stream sinks.

---
 rtl/int_to_double.sv | 150 +++++++++++++++
 tb/tb_int_to_double.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/int_to_double.sv
// Four-stage pipelined 64-bit signed integer to IEEE 754 binary64 converter.
// Rounds to nearest, ties to even; zero always yields +0.0.
module int_to_double (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a,
  output logic [63:0] z
);

  // Stage 1: sign, magnitude, nonzero flag
  logic        s1_s_q;
  logic        s1_s_d;
  logic        s1_nz_q;
  logic        s1_nz_d;
  logic [63:0] s1_m_q;
  logic [63:0] s1_m_d;

  always_comb begin
    s1_s_d  = a[63];
    s1_m_d  = a[63] ? (~a + 64'd1) : a;
    s1_nz_d = (a != 64'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_s_q  <= 1'b0;
      s1_nz_q <= 1'b0;
      s1_m_q  <= 64'd0;
    end else begin
      s1_s_q  <= s1_s_d;
      s1_nz_q <= s1_nz_d;
      s1_m_q  <= s1_m_d;
    end
  end

  // Stage 2: leading-zero count
  logic        s2_s_q;
  logic        s2_nz_q;
  logic [63:0] s2_m_q;
  logic [5:0]  s2_lz_q;
  logic [5:0]  s2_lz_d;
  logic        lz_found;

  always_comb begin
    s2_lz_d  = 6'd0;
    lz_found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!lz_found && s1_m_q[i]) begin
        s2_lz_d  = 6'(63 - i);
        lz_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_s_q  <= 1'b0;
      s2_nz_q <= 1'b0;
      s2_m_q  <= 64'd0;
      s2_lz_q <= 6'd0;
    end else begin
      s2_s_q  <= s1_s_q;
      s2_nz_q <= s1_nz_q;
      s2_m_q  <= s1_m_q;
      s2_lz_q <= s2_lz_d;
    end
  end

  // Stage 3: normalize so the leading one sits in bit 63
  logic        s3_s_q;
  logic        s3_nz_q;
  logic [63:0] s3_n_q;
  logic [63:0] s3_n_d;
  logic [10:0] s3_e_q;
  logic [10:0] s3_e_d;

  always_comb begin
    s3_n_d = s2_m_q << s2_lz_q;
    s3_e_d = 11'd1086 - {5'd0, s2_lz_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_s_q  <= 1'b0;
      s3_nz_q <= 1'b0;
      s3_n_q  <= 64'd0;
      s3_e_q  <= 11'd0;
    end else begin
      s3_s_q  <= s2_s_q;
      s3_nz_q <= s2_nz_q;
      s3_n_q  <= s3_n_d;
      s3_e_q  <= s3_e_d;
    end
  end

  // Stage 4: round to nearest even; a fraction carry bumps the exponent
  logic        s4_s_q;
  logic        s4_nz_q;
  logic [51:0] s4_f_q;
  logic [51:0] s4_f_d;
  logic [10:0] s4_e_q;
  logic [10:0] s4_e_d;
  logic [51:0] frac;
  logic        guard;
  logic        sticky;
  logic        rnd_up;
  logic        rnd_c;

  always_comb begin
    frac   = s3_n_q[62:11];
    guard  = s3_n_q[10];
    sticky = |s3_n_q[9:0];
    rnd_up = guard & (sticky | frac[0]);
    {rnd_c, s4_f_d} = {1'b0, frac} + {52'd0, rnd_up};
    s4_e_d = s3_e_q + {10'd0, rnd_c};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s4_s_q  <= 1'b0;
      s4_nz_q <= 1'b0;
      s4_f_q  <= 52'd0;
      s4_e_q  <= 11'd0;
    end else begin
      s4_s_q  <= s3_s_q;
      s4_nz_q <= s3_nz_q;
      s4_f_q  <= s4_f_d;
      s4_e_q  <= s4_e_d;
    end
  end

  // Output register: pack, flushed or zero slots give +0.0
  logic [63:0] z_q;
  logic [63:0] z_d;

  always_comb begin
    z_d = s4_nz_q ? {s4_s_q, s4_e_q, s4_f_q} : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q <= 64'd0;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_int_to_double.sv
// Scoreboard bench for int_to_double: directed vectors, random stream,
// mid-stream reset; expected results checked four cycles after sampling.
module tb_int_to_double;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] z;

  int checks;
  int fails;
  int slot;

  logic [63:0] exp_q[$];

  int_to_double dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .z    (z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] ref_cvt(input logic [63:0] v);
    logic        s;
    logic [63:0] m;
    logic [63:0] mant;
    logic [63:0] rem;
    logic [63:0] half;
    logic [63:0] one;
    int          p;
    int          sh;
    logic [10:0] e;
    if (v == 64'd0) return 64'd0;
    one = 64'd1;
    s = v[63];
    m = s ? (64'd0 - v) : v;
    p = 0;
    for (int i = 0; i < 64; i++)
      if (m[i]) p = i;
    if (p <= 52) begin
      mant = m << (52 - p);
    end else begin
      sh   = p - 52;
      mant = m >> sh;
      rem  = m & ((one << sh) - one);
      half = one << (sh - 1);
      if (rem > half || (rem == half && mant[0]))
        mant = mant + one;
      if (mant == (one << 53)) begin
        mant = mant >> 1;
        p    = p + 1;
      end
    end
    e = 11'(1023 + p);
    return {s, e, mant[51:0]};
  endfunction

  task automatic drive(input logic rst, input logic [63:0] v,
                       input logic [63:0] e);
    @(negedge clk);
    rst_n = rst;
    a     = v;
    if (!rst) begin
      foreach (exp_q[i]) exp_q[i] = 64'd0;
      exp_q.push_back(64'd0);
    end else begin
      exp_q.push_back(e);
    end
  endtask

  initial begin
    logic [63:0] e;
    slot = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() >= 5) begin
        e = exp_q.pop_front();
        checks++;
        if (z !== e) begin
          fails++;
          $display("FAIL slot%0d: z=%h expected %h", slot, z, e);
        end
        slot++;
      end
    end
  end

  initial begin : watchdog
    #(400000);
    checks++;
    fails++;
    $display("FAIL timeout: stimulus did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    logic [63:0] v;
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    a      = 64'd5;
    exp_q.push_back(64'd0);

    drive(1'b0, 64'd5, 64'd0);
    drive(1'b0, 64'd5, 64'd0);
    @(posedge clk);
    #1;
    checks++;
    if (z !== 64'd0) begin
      fails++;
      $display("FAIL reset: z=%h expected 0", z);
    end
    for (int i = 0; i < 6; i++)
      drive(1'b1, 64'd5, 64'h4014000000000000);

    drive(1'b1, 64'd0, 64'h0000000000000000);
    drive(1'b1, 64'd1, 64'h3FF0000000000000);
    drive(1'b1, -64'sd1, 64'hBFF0000000000000);
    drive(1'b1, 64'd3, 64'h4008000000000000);

    drive(1'b1, 64'd9007199254740993, 64'h4340000000000000);
    drive(1'b1, 64'd9007199254740995, 64'h4340000000000002);
    drive(1'b1, -64'sd9007199254740993, 64'hC340000000000000);
    drive(1'b1, 64'h7FFFFFFFFFFFFFFF, 64'h43E0000000000000);
    drive(1'b1, 64'h8000000000000000, 64'hC3E0000000000000);
    drive(1'b1, 64'd9007199254740992, 64'h4340000000000000);
    drive(1'b1, 64'd9007199254740991, 64'h433FFFFFFFFFFFFF);
    drive(1'b1, 64'd0, 64'h0000000000000000);

    for (int i = 0; i < 10000; i++) begin
      v = {$urandom, $urandom};
      if (i % 3 == 1) v = v >> $urandom_range(63, 0);
      if (i % 7 == 3) v = -v;
      if (i == 5000)
        drive(1'b0, v, 64'd0);
      else
        drive(1'b1, v, ref_cvt(v));
    end

    for (int i = 0; i < 6; i++)
      drive(1'b1, 64'd0, 64'd0);
    @(posedge clk);
    #2;
    disable watchdog;

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
